// File: rtl/pool_window_regfile_pkg.sv
// pool_pkg: shared types and defaults for the multi-channel pooling register file.
package pool_pkg;
    localparam int POOL_DATA_W = 16;
    typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} pool_state_e;
endpackage

// File: rtl/pool_window_regfile_lane.sv
// pool_lane: one channel's window accumulator plus its registered pooled result.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DATA_W  = POOL_DATA_W,
    parameter int LOG_WIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_last,
    input  pool_mode_e        i_mode,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);
    localparam int ACC_W = DATA_W + LOG_WIN;
    logic signed [ACC_W-1:0] r_acc, w_in, w_next, w_avg;
    logic        [DATA_W-1:0] r_out;
    assign w_in   = ACC_W'($signed(i_data));
    assign w_next = i_load ? w_in :
                    (i_mode == POOL_AVG) ? r_acc + w_in :
                    (w_in > r_acc) ? w_in : r_acc;
    // Flooring shift; the wide accumulator guarantees the mean fits DATA_W.
    assign w_avg  = w_next >>> LOG_WIN;
    assign o_data = r_out;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (i_en) r_acc <= w_next;
            if (i_last) r_out <= DATA_W'((i_mode == POOL_AVG) ? w_avg : w_next);
        end
    end
endmodule

// File: rtl/pool_window_regfile.sv
// pool_window_regfile: reduces WIN consecutive sample vectors per channel to one
// pooled vector (max or average) with valid/ready on both sides and no bubble.
module pool_window_regfile
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int NUM_CH = 4,
    parameter int WIN    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH*DATA_W-1:0] out_data_o,
    output logic                     busy_o
);
    localparam int LOG_WIN = $clog2(WIN);
    pool_state_e        r_state;
    pool_mode_e         r_mode;
    logic [LOG_WIN-1:0] r_cnt;
    logic               w_acc, w_load, w_last;
    pool_mode_e         w_mode;
    // In HOLD a consumed result frees the slot in the same cycle, so accept then too.
    assign in_ready_o  = !flush_i && (r_state == ACCUM || out_ready_i);
    assign w_acc       = in_valid_i && in_ready_o;
    assign w_load      = w_acc && (r_cnt == '0);
    assign w_last      = w_acc && (r_cnt == LOG_WIN'(WIN - 1));
    assign w_mode      = w_load ? pool_mode_e'(mode_i) : r_mode;
    assign out_valid_o = (r_state == HOLD);
    assign busy_o      = (r_cnt != '0) || out_valid_o;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_mode  <= POOL_MAX;
        end else if (flush_i) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
        end else begin
            if (w_acc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_load) r_mode <= pool_mode_e'(mode_i);
            r_state <= w_last ? HOLD : (r_state == HOLD && out_ready_i) ? ACCUM : r_state;
        end
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        pool_lane #(.DATA_W(DATA_W), .LOG_WIN(LOG_WIN)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_acc),
            .i_load (w_load),
            .i_last (w_last),
            .i_mode (w_mode),
            .i_data (in_data_i[c*DATA_W +: DATA_W]),
            .o_data (out_data_o[c*DATA_W +: DATA_W])
        );
    end
endmodule
